// File: rtl/lcd8080_pkg.sv
// Shared opcodes, sequencer states and panel defaults for the 8080-bus LCD command sequencer.
package lcd8080_pkg;

  localparam int H_RES_DEF = 480;
  localparam int V_RES_DEF = 272;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PARAM = 2'd1,
    ST_MEMWR = 2'd2
  } state_e;

  function automatic logic [9:0] clamp_coord(input logic [15:0] v, input logic [15:0] vmax);
    return (v > vmax) ? vmax[9:0] : v[9:0];
  endfunction

endpackage

// File: rtl/j80_sync_edge.sv
// Two-flop synchronisers for the 8080 bus and a WRn rising-edge detector that captures RS/Din.
module j80_sync_edge (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_n,
  input  logic       rd_n,
  input  logic       rs,
  input  logic [7:0] din,
  output logic       wr_rise,
  output logic       wr_rs,
  output logic [7:0] wr_din,
  output logic       rd_n_s,
  output logic       rs_s
);

  logic [1:0] wr_sync_q;
  logic [1:0] rd_sync_q;
  logic [1:0] rs_sync_q;
  logic [7:0] din_s1_q;
  logic [7:0] din_s2_q;
  logic       wr_prev_q;
  logic       rise_q, rise_d;
  logic       cap_rs_q, cap_rs_d;
  logic [7:0] cap_din_q, cap_din_d;

  // RS/Din travel through the same two stages as WRn, so they line up with the detected edge.
  always_comb begin
    rise_d    = wr_sync_q[1] & ~wr_prev_q;
    cap_rs_d  = rise_d ? rs_sync_q[1] : cap_rs_q;
    cap_din_d = rise_d ? din_s2_q : cap_din_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync_q <= 2'b11;
      rd_sync_q <= 2'b11;
      rs_sync_q <= 2'b00;
      din_s1_q  <= 8'h00;
      din_s2_q  <= 8'h00;
      wr_prev_q <= 1'b1;
      rise_q    <= 1'b0;
      cap_rs_q  <= 1'b0;
      cap_din_q <= 8'h00;
    end else begin
      wr_sync_q <= {wr_sync_q[0], wr_n};
      rd_sync_q <= {rd_sync_q[0], rd_n};
      rs_sync_q <= {rs_sync_q[0], rs};
      din_s1_q  <= din;
      din_s2_q  <= din_s1_q;
      wr_prev_q <= wr_sync_q[1];
      rise_q    <= rise_d;
      cap_rs_q  <= cap_rs_d;
      cap_din_q <= cap_din_d;
    end
  end

  assign wr_rise = rise_q;
  assign wr_rs   = cap_rs_q;
  assign wr_din  = cap_din_q;
  assign rd_n_s  = rd_sync_q[1];
  assign rs_s    = rs_sync_q[1];

endmodule

// File: rtl/lcd8080_cmd_seq.sv
// 8080-bus LCD command sequencer: decodes window/memory-write commands and emits RGB565 pixels
// with X/Y coordinates that scan the programmed column/page window.
module lcd8080_cmd_seq
  import lcd8080_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        J80_WRn,
  input  logic        J80_RDn,
  input  logic        J80_RS,
  input  logic [7:0]  J80_Din,
  output logic [7:0]  J80_Dout,
  output logic        J80_Doe,
  input  logic        FIFO_FULL,
  output logic        PIX_WE,
  output logic [15:0] PIX_DATA,
  output logic [9:0]  PIX_X,
  output logic [9:0]  PIX_Y,
  output logic        FRAME_START,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] H_MAX  = 16'(H_RES - 1);
  localparam logic [15:0] V_MAX  = 16'(V_RES - 1);
  localparam logic [9:0]  H_LAST = H_MAX[9:0];
  localparam logic [9:0]  V_LAST = V_MAX[9:0];

  logic       wr_rise, wr_rs, rd_n_s, rs_s;
  logic [7:0] wr_din;

  j80_sync_edge u_sync (
    .clk     (CLK),
    .rst_n   (nRST),
    .wr_n    (J80_WRn),
    .rd_n    (J80_RDn),
    .rs      (J80_RS),
    .din     (J80_Din),
    .wr_rise (wr_rise),
    .wr_rs   (wr_rs),
    .wr_din  (wr_din),
    .rd_n_s  (rd_n_s),
    .rs_s    (rs_s)
  );

  logic       byte_vld_q, byte_rs_q;
  logic [7:0] byte_din_q;

  state_e      state_q, state_d;
  logic        sel_page_q, sel_page_d;
  logic [1:0]  pcnt_q, pcnt_d;
  logic [23:0] pbuf_q, pbuf_d;
  logic [9:0]  col_s_q, col_s_d, col_e_q, col_e_d;
  logic [9:0]  page_s_q, page_s_d, page_e_q, page_e_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        hi_phase_q, hi_phase_d;
  logic [7:0]  hi_byte_q, hi_byte_d;
  logic        ovf_q, ovf_d;
  logic        pix_we_q, pix_we_d;
  logic [15:0] pix_data_q, pix_data_d;
  logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic        frame_start_q, frame_start_d;
  logic [7:0]  dout_q, dout_d;

  logic [15:0] lim_max;
  logic [9:0]  cl_s, cl_e;

  // Window commit happens on the 4th parameter byte; the first three sit in pbuf.
  always_comb begin
    lim_max = sel_page_q ? V_MAX : H_MAX;
    cl_s    = clamp_coord(pbuf_q[23:8], lim_max);
    cl_e    = clamp_coord({pbuf_q[7:0], byte_din_q}, lim_max);
    if (cl_e < cl_s) cl_e = cl_s;
  end

  always_comb begin
    state_d       = state_q;
    sel_page_d    = sel_page_q;
    pcnt_d        = pcnt_q;
    pbuf_d        = pbuf_q;
    col_s_d       = col_s_q;
    col_e_d       = col_e_q;
    page_s_d      = page_s_q;
    page_e_d      = page_e_q;
    x_d           = x_q;
    y_d           = y_q;
    hi_phase_d    = hi_phase_q;
    hi_byte_d     = hi_byte_q;
    ovf_d         = ovf_q;
    pix_we_d      = 1'b0;
    pix_data_d    = pix_data_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = 1'b0;
    dout_d        = {ovf_q, (state_q == ST_MEMWR), FIFO_FULL, 5'b00000};

    if (byte_vld_q) begin
      if (!byte_rs_q) begin
        state_d = ST_IDLE;
        case (byte_din_q)
          OP_NOP: ;
          OP_SWRESET: begin
            sel_page_d = 1'b0;
            pcnt_d     = 2'd0;
            pbuf_d     = 24'h0;
            col_s_d    = 10'd0;
            col_e_d    = H_LAST;
            page_s_d   = 10'd0;
            page_e_d   = V_LAST;
            x_d        = 10'd0;
            y_d        = 10'd0;
            hi_phase_d = 1'b1;
            hi_byte_d  = 8'h00;
            ovf_d      = 1'b0;
            pix_data_d = 16'h0000;
            pix_x_d    = 10'd0;
            pix_y_d    = 10'd0;
            dout_d     = 8'h00;
          end
          OP_CASET, OP_PASET: begin
            state_d    = ST_PARAM;
            sel_page_d = (byte_din_q == OP_PASET);
            pcnt_d     = 2'd0;
          end
          OP_RAMWR: begin
            state_d       = ST_MEMWR;
            x_d           = col_s_q;
            y_d           = page_s_q;
            hi_phase_d    = 1'b1;
            frame_start_d = 1'b1;
          end
          default: ;
        endcase
      end else begin
        case (state_q)
          ST_PARAM: begin
            if (pcnt_q == 2'd3) begin
              state_d = ST_IDLE;
              if (sel_page_q) begin
                page_s_d = cl_s;
                page_e_d = cl_e;
              end else begin
                col_s_d = cl_s;
                col_e_d = cl_e;
              end
            end else begin
              pbuf_d = {pbuf_q[15:0], byte_din_q};
              pcnt_d = pcnt_q + 2'd1;
            end
          end
          ST_MEMWR: begin
            if (hi_phase_q) begin
              hi_byte_d  = byte_din_q;
              hi_phase_d = 1'b0;
            end else begin
              hi_phase_d = 1'b1;
              pix_data_d = {hi_byte_q, byte_din_q};
              pix_x_d    = x_q;
              pix_y_d    = y_q;
              // A full FIFO drops the pixel but the scan position still moves on.
              if (FIFO_FULL) ovf_d = 1'b1;
              else pix_we_d = 1'b1;
              if (x_q < col_e_q) begin
                x_d = x_q + 10'd1;
              end else begin
                x_d = col_s_q;
                y_d = (y_q == page_e_q) ? page_s_q : y_q + 10'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      byte_vld_q    <= 1'b0;
      byte_rs_q     <= 1'b0;
      byte_din_q    <= 8'h00;
      state_q       <= ST_IDLE;
      sel_page_q    <= 1'b0;
      pcnt_q        <= 2'd0;
      pbuf_q        <= 24'h0;
      col_s_q       <= 10'd0;
      col_e_q       <= H_LAST;
      page_s_q      <= 10'd0;
      page_e_q      <= V_LAST;
      x_q           <= 10'd0;
      y_q           <= 10'd0;
      hi_phase_q    <= 1'b1;
      hi_byte_q     <= 8'h00;
      ovf_q         <= 1'b0;
      pix_we_q      <= 1'b0;
      pix_data_q    <= 16'h0000;
      pix_x_q       <= 10'd0;
      pix_y_q       <= 10'd0;
      frame_start_q <= 1'b0;
      dout_q        <= 8'h00;
    end else begin
      byte_vld_q    <= wr_rise;
      byte_rs_q     <= wr_rs;
      byte_din_q    <= wr_din;
      state_q       <= state_d;
      sel_page_q    <= sel_page_d;
      pcnt_q        <= pcnt_d;
      pbuf_q        <= pbuf_d;
      col_s_q       <= col_s_d;
      col_e_q       <= col_e_d;
      page_s_q      <= page_s_d;
      page_e_q      <= page_e_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hi_phase_q    <= hi_phase_d;
      hi_byte_q     <= hi_byte_d;
      ovf_q         <= ovf_d;
      pix_we_q      <= pix_we_d;
      pix_data_q    <= pix_data_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      frame_start_q <= frame_start_d;
      dout_q        <= dout_d;
    end
  end

  assign J80_Doe     = ~rd_n_s & rs_s;
  assign J80_Dout    = dout_q;
  assign PIX_WE      = pix_we_q;
  assign PIX_DATA    = pix_data_q;
  assign PIX_X       = pix_x_q;
  assign PIX_Y       = pix_y_q;
  assign FRAME_START = frame_start_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_lcd8080_cmd_seq.sv
// Bench for lcd8080_cmd_seq: directed vector table, hand corner sequences, and random bytes
// checked against a window/scan reference model with a pixel scoreboard.
module tb_lcd8080_cmd_seq;

  localparam int HR = 480;
  localparam int VR = 272;

  logic        CLK, nRST, J80_WRn, J80_RDn, J80_RS, FIFO_FULL;
  logic [7:0]  J80_Din, J80_Dout;
  logic        J80_Doe, PIX_WE, FRAME_START;
  logic [15:0] PIX_DATA;
  logic [9:0]  PIX_X, PIX_Y;
  logic [1:0]  dbg_state;

  lcd8080_cmd_seq #(.H_RES(HR), .V_RES(VR)) dut (
    .CLK(CLK), .nRST(nRST), .J80_WRn(J80_WRn), .J80_RDn(J80_RDn), .J80_RS(J80_RS),
    .J80_Din(J80_Din), .J80_Dout(J80_Dout), .J80_Doe(J80_Doe), .FIFO_FULL(FIFO_FULL),
    .PIX_WE(PIX_WE), .PIX_DATA(PIX_DATA), .PIX_X(PIX_X), .PIX_Y(PIX_Y),
    .FRAME_START(FRAME_START), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int checks = 0;
  int failures = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endfunction

  // reference model: window registers, scan position and byte phase as plain integers
  int          m_mode;  // 0 idle, 1 collecting parameters, 2 memory write
  bit          m_page;
  logic [7:0]  m_par[$];
  int          m_cs, m_ce, m_ps, m_pe, m_x, m_y;
  bit          m_hi_next;
  logic [7:0]  m_hi;
  bit          m_ovf;
  int          m_fs = 0;
  logic [35:0] exp_q[$];

  function automatic void model_reset();
    m_mode = 0; m_page = 0; m_par.delete();
    m_cs = 0; m_ce = HR - 1; m_ps = 0; m_pe = VR - 1;
    m_x = 0; m_y = 0; m_hi_next = 1; m_hi = 8'h00; m_ovf = 0;
  endfunction

  function automatic void model_byte(input logic rs, input logic [7:0] d, input logic ff);
    int s, e, lim;
    if (!rs) begin
      m_par.delete();
      m_mode = 0;
      if (d == 8'h01) model_reset();
      else if (d == 8'h2A || d == 8'h2B) begin m_mode = 1; m_page = (d == 8'h2B); end
      else if (d == 8'h2C) begin
        m_mode = 2; m_x = m_cs; m_y = m_ps; m_hi_next = 1; m_fs++;
      end
    end else if (m_mode == 1) begin
      m_par.push_back(d);
      if (m_par.size() == 4) begin
        lim = m_page ? VR : HR;
        s = m_par[0] * 256 + m_par[1];
        e = m_par[2] * 256 + m_par[3];
        if (s > lim - 1) s = lim - 1;
        if (e > lim - 1) e = lim - 1;
        if (e < s) e = s;
        if (m_page) begin m_ps = s; m_pe = e; end
        else begin m_cs = s; m_ce = e; end
        m_par.delete();
        m_mode = 0;
      end
    end else if (m_mode == 2) begin
      if (m_hi_next) begin
        m_hi = d; m_hi_next = 0;
      end else begin
        m_hi_next = 1;
        if (ff) m_ovf = 1;
        else exp_q.push_back({10'(m_x), 10'(m_y), m_hi, d});
        if (m_x < m_ce) m_x++;
        else begin
          m_x = m_cs;
          if (m_y == m_pe) m_y = m_ps; else m_y++;
        end
      end
    end
  endfunction

  // scoreboard / monitor
  int we_seen = 0;
  int fs_seen = 0;
  int last_x, last_y, last_d;
  logic [35:0] exp_pix;

  always @(negedge CLK) begin
    if (FRAME_START) fs_seen++;
    if (PIX_WE) begin
      we_seen++;
      last_x = int'(PIX_X);
      last_y = int'(PIX_Y);
      last_d = int'(PIX_DATA);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pixel_unexpected: got x=%0d y=%0d data=%h, expected no pixel",
                 PIX_X, PIX_Y, PIX_DATA);
      end else begin
        exp_pix = exp_q.pop_front();
        if ({PIX_X, PIX_Y, PIX_DATA} !== exp_pix) begin
          failures++;
          $display("FAIL pixel_scoreboard: got x=%0d y=%0d data=%h expected x=%0d y=%0d data=%h",
                   PIX_X, PIX_Y, PIX_DATA, exp_pix[35:26], exp_pix[25:16], exp_pix[15:0]);
        end
      end
    end
  end

  // driver tasks
  int last_lat;

  task automatic write_byte(input logic rs, input logic [7:0] d);
    @(negedge CLK);
    J80_RS = rs; J80_Din = d; J80_WRn = 1'b0;
    repeat (3) @(negedge CLK);
    J80_WRn = 1'b1;
    model_byte(rs, d, FIFO_FULL);
    last_lat = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge CLK);
      if (PIX_WE && last_lat == 0) last_lat = k;
    end
  endtask

  task automatic read_status(input string name);
    @(negedge CLK);
    J80_RS = 1'b1; J80_RDn = 1'b0;
    repeat (4) @(negedge CLK);
    chk({name, "_doe"}, int'(J80_Doe), 1);
    chk({name, "_dout"}, int'(J80_Dout), int'({m_ovf, (m_mode == 2), FIFO_FULL, 5'b00000}));
    J80_RDn = 1'b1;
    repeat (4) @(negedge CLK);
    chk({name, "_doe_off"}, int'(J80_Doe), 0);
  endtask

  task automatic hard_reset();
    @(negedge CLK);
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
  endtask

  typedef struct {
    logic        rs;
    logic [7:0]  d;
    logic        we;
    int          x;
    int          y;
    logic [15:0] pd;
    logic        fs;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rs, input logic [7:0] d, input logic we,
                              input int x, input int y, input logic [15:0] pd, input logic fs);
    vec_t v;
    v.rs = rs; v.d = d; v.we = we; v.x = x; v.y = y; v.pd = pd; v.fs = fs;
    return v;
  endfunction

  int we0, fs0;
  logic [7:0] rd;
  logic [15:0] pw;

  initial begin
    nRST = 1'b0; J80_WRn = 1'b1; J80_RDn = 1'b1; J80_RS = 1'b0; J80_Din = 8'h00; FIFO_FULL = 1'b0;
    model_reset();

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_pix_we", int'(PIX_WE), 0);
    chk("rst_frame_start", int'(FRAME_START), 0);
    chk("rst_doe", int'(J80_Doe), 0);
    chk("rst_dout", int'(J80_Dout), 0);
    chk("rst_pix_data", int'(PIX_DATA), 0);
    chk("rst_pix_xy", int'({PIX_X, PIX_Y}), 0);
    chk("rst_state_idle", int'(dbg_state), 0);
    nRST = 1'b1;
    repeat (2) @(negedge CLK);

    // table: basic two-pixel write, then windowed scan with wrap
    vq.push_back(mk(0, 8'h2C, 0, 0, 0, 16'h0, 1));
    vq.push_back(mk(1, 8'hF8, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h00, 1, 0, 0, 16'hF800, 0));
    vq.push_back(mk(1, 8'h07, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'hE0, 1, 1, 0, 16'h07E0, 0));
    vq.push_back(mk(0, 8'h2A, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h00, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h0A, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h00, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h0B, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(0, 8'h2B, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h00, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h05, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h00, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h06, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(0, 8'h2C, 0, 0, 0, 16'h0, 1));
    vq.push_back(mk(1, 8'hA1, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h01, 1, 10, 5, 16'hA101, 0));
    vq.push_back(mk(1, 8'hA2, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h02, 1, 11, 5, 16'hA202, 0));
    vq.push_back(mk(1, 8'hA3, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h03, 1, 10, 6, 16'hA303, 0));
    vq.push_back(mk(1, 8'hA4, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h04, 1, 11, 6, 16'hA404, 0));
    vq.push_back(mk(1, 8'hA5, 0, 0, 0, 16'h0, 0));
    vq.push_back(mk(1, 8'h05, 1, 10, 5, 16'hA505, 0));

    for (int i = 0; i < vq.size(); i++) begin
      we0 = we_seen; fs0 = fs_seen;
      write_byte(vq[i].rs, vq[i].d);
      chk($sformatf("vec%0d_we", i), we_seen - we0, int'(vq[i].we));
      chk($sformatf("vec%0d_fs", i), fs_seen - fs0, int'(vq[i].fs));
      if (vq[i].we) begin
        chk($sformatf("vec%0d_x", i), last_x, vq[i].x);
        chk($sformatf("vec%0d_y", i), last_y, vq[i].y);
        chk($sformatf("vec%0d_data", i), last_d, int'(vq[i].pd));
        chk($sformatf("vec%0d_latency_edges", i), last_lat - 1, 4);
      end
    end

    // start beyond the panel clamps to the last column; end below start follows it
    write_byte(0, 8'h01);
    write_byte(0, 8'h2A);
    write_byte(1, 8'h01); write_byte(1, 8'hF4); write_byte(1, 8'h00); write_byte(1, 8'h00);
    write_byte(0, 8'h2C);
    write_byte(1, 8'hAA); write_byte(1, 8'h55);
    chk("clamp_px1_x", last_x, 479);
    chk("clamp_px1_y", last_y, 0);
    write_byte(1, 8'h12); write_byte(1, 8'h34);
    chk("clamp_px2_x", last_x, 479);
    chk("clamp_px2_y", last_y, 1);

    // overflow: FIFO full on the middle pixel of three
    write_byte(0, 8'h01);
    write_byte(0, 8'h2C);
    we0 = we_seen;
    for (int p = 0; p < 3; p++) begin
      FIFO_FULL = (p == 1);
      write_byte(1, 8'h30 + 8'(p)); write_byte(1, 8'hC0 + 8'(p));
    end
    FIFO_FULL = 1'b0;
    chk("ovf_we_count", we_seen - we0, 2);
    chk("ovf_last_x", last_x, 2);
    read_status("ovf_set");
    write_byte(0, 8'h01);
    read_status("ovf_cleared");

    // aborted memory write: stray high byte is discarded by the following 0x2C
    we0 = we_seen; fs0 = fs_seen;
    write_byte(0, 8'h2C);
    write_byte(1, 8'hDE);
    write_byte(0, 8'h00);
    write_byte(0, 8'h2C);
    write_byte(1, 8'h5A); write_byte(1, 8'hC3);
    chk("abort_we_count", we_seen - we0, 1);
    chk("abort_fs_count", fs_seen - fs0, 2);
    chk("abort_xy", last_x * 1024 + last_y, 0);
    chk("abort_data", last_d, 16'h5AC3);

    // data bytes in IDLE do nothing
    we0 = we_seen;
    write_byte(0, 8'h00);
    write_byte(1, 8'h11); write_byte(1, 8'h22);
    chk("idle_data_ignored", we_seen - we0, 0);

    // asynchronous reset in the middle of a memory write
    write_byte(0, 8'h2C);
    write_byte(1, 8'h12); write_byte(1, 8'h34);
    write_byte(1, 8'h56); write_byte(1, 8'h78);
    write_byte(1, 8'h9A);
    chk("pre_reset_x", int'(PIX_X), 1);
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_pix_data", int'(PIX_DATA), 0);
    chk("async_rst_pix_xy", int'({PIX_X, PIX_Y}), 0);
    chk("async_rst_strobes", int'({PIX_WE, FRAME_START, J80_Doe}), 0);
    chk("async_rst_dout", int'(J80_Dout), 0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
    write_byte(0, 8'h2C);
    write_byte(1, 8'h0F); write_byte(1, 8'hF0);
    chk("post_reset_xy", last_x * 1024 + last_y, 0);

    // random bytes against the model
    hard_reset();
    repeat (180) begin
      FIFO_FULL = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: rd = 8'h2A;
          1: rd = 8'h2B;
          2: rd = 8'h2C;
          3: rd = 8'h00;
          4: rd = 8'h01;
          default: rd = 8'($urandom_range(2, 255));
        endcase
        write_byte(0, rd);
      end else begin
        rd = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 2));
        write_byte(1, rd);
      end
    end
    FIFO_FULL = 1'b1;
    read_status("rand_status_ff");
    FIFO_FULL = 1'b0;
    pw = 16'($urandom_range(0, 65535));
    read_status("rand_status");
    write_byte(0, 8'h2C);
    write_byte(1, pw[15:8]); write_byte(1, pw[7:0]);
    repeat (4) @(negedge CLK);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("frame_start_total", fs_seen, m_fs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd8080_cmd_seq.md
LCD8080_CMD_SEQ -- requirements
Module: lcd8080_cmd_seq

Interface
REQ-001 SHALL have parameter H_RES, default 480, meaning panel width in pixels.
REQ-002 SHALL have parameter V_RES, default 272, meaning panel height in lines.
REQ-003 SHALL have port CLK  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port nRST  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port J80_WRn  in  1  8080 write strobe, active low; data latched on its rising edge.
REQ-006 SHALL have port J80_RDn  in  1  8080 read strobe, active low.
REQ-007 SHALL have port J80_RS  in  1  register select: 0 = command byte, 1 = data/parameter byte.
REQ-008 SHALL have port J80_Din  in  8  bus write data.
REQ-009 SHALL have port J80_Dout  out  8  status byte {OVF, MEMWR, FIFO_FULL, 5'b0}.
REQ-010 SHALL have port J80_Doe  out  1  bus drive enable for J80_Dout.
REQ-011 SHALL have port FIFO_FULL  in  1  downstream pixel FIFO full.
REQ-012 SHALL have port PIX_WE  out  1  one-cycle pixel write strobe.
REQ-013 SHALL have port PIX_DATA  out  16  RGB565 pixel.
REQ-014 SHALL have ports PIX_X and PIX_Y  out  10 each  pixel coordinates.
REQ-015 SHALL have port FRAME_START  out  1  one-cycle pulse on each accepted 0x2C command.

Function
REQ-016 SHALL pass J80_WRn, J80_RDn, J80_RS and J80_Din through a 2-flop synchroniser and detect WRn rising edge on the synchronised signal; strobe low/high time >= 2 CLK each.
REQ-017 SHALL act on a byte in the cycle after edge detection; PIX_WE asserts exactly 4 CLK edges after the first edge sampling J80_WRn high.
REQ-018 SHALL decode command bytes: 0x00 NOP, 0x01 soft reset, 0x2A column window, 0x2B page window, 0x2C memory write; other opcodes SHALL return to IDLE with no effect.
REQ-019 SHALL implement states IDLE, PARAM, MEMWR; a command byte in any state SHALL abort the current state and be decoded afresh.
REQ-020 In PARAM, SHALL collect 4 data bytes (start hi, start lo, end hi, end lo) into the selected window, commit on the 4th byte, then return to IDLE; fewer than 4 bytes SHALL leave the window unchanged.
REQ-021 SHALL clamp committed start/end to H_RES-1 (column) or V_RES-1 (page), and set end = start if end < start after clamping.
REQ-022 On 0x2C SHALL load X = column start, Y = page start, byte phase = high, pulse FRAME_START, enter MEMWR.
REQ-023 In MEMWR, first data byte SHALL be PIX_DATA[15:8], second PIX_DATA[7:0]; PIX_WE SHALL pulse with current X/Y on the second byte.
REQ-024 After each pixel: if X < column end, X+1; else X = column start and Y+1, or Y = page start when Y = page end (wrap).
REQ-025 If FIFO_FULL is high when a pixel completes, SHALL suppress PIX_WE, set sticky OVF, and still advance X/Y.
REQ-026 OVF SHALL clear only on reset or 0x01; data bytes in IDLE SHALL be ignored.
REQ-027 J80_Doe SHALL be high while synchronised RDn is low and RS = 1; J80_Dout SHALL be registered status.
REQ-028 Window registers SHALL update only while not in MEMWR.

Reset
REQ-029 On nRST low: state IDLE, column window 0..H_RES-1, page window 0..V_RES-1, X = Y = 0, OVF = 0, PIX_WE = FRAME_START = J80_Doe = 0, PIX_DATA = 0, sync flops = idle-high for strobes.
REQ-030 Command 0x01 SHALL apply the same values except synchroniser flops, effective the cycle after decode.

Structure
REQ-031 Package lcd8080_pkg SHALL hold opcode constants, state enum and default H_RES/V_RES.
REQ-032 Sub-module j80_sync_edge SHALL hold synchronisers and WR edge detector.

Verification
REQ-033 Reset then 0x2C, bytes F8,00,07,E0 -> PIX_WE twice: (0,0)=F800, (1,0)=07E0; FRAME_START once.
REQ-034 0x2A 00,0A,00,0B; 0x2B 00,05,00,06; 0x2C; 5 pixels -> coords (10,5),(11,5),(10,6),(11,6),(10,5).
REQ-035 0x2A 01,F4,00,00 -> column window 479..479.
REQ-036 FIFO_FULL high during pixel 2 of 3 -> PIX_WE for pixels 1 and 3 only at X = 0, 2; OVF reads 1; 0x01 clears it.
REQ-037 0x2C, one data byte, then 0x00, 0x2C, 2 bytes -> single pixel at (0,0) built from bytes after the second 0x2C.
REQ-038 nRST pulse mid-MEMWR -> all outputs zero same cycle; next 0x2C restarts at (0,0).
